// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache.
// Zero-latency hits; whole-line sequential refill over a req/ack bus.
module icache_dm #(
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [63:0] PC,
    input  logic        FLUSH,
    output logic        icache_r,
    output logic [31:0] instruction,
    output logic        icache_fault,
    output logic        MEM_REQ,
    output logic [63:0] MEM_ADDR,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ERR
);
    localparam int WB = $clog2(LINE_WORDS);
    localparam int SB = $clog2(SETS);
    localparam int LW = 64 - WB - 2;
    localparam int TW = LW - SB;

    typedef enum logic [1:0] {IDLE, REFILL, ERR} state_t;

    state_t state_q, state_d;

    logic [SETS-1:0] valid_q;
    logic [TW-1:0]   tag_q  [SETS];
    logic [31:0]     data_q [SETS][LINE_WORDS];

    logic [LW-1:0] line_q, line_d;
    logic [LW-1:0] err_q, err_d;
    logic [WB-1:0] beat_q, beat_d, beat_inc;
    logic          fp_q, fp_d;
    logic          req_d;
    logic [63:0]   addr_d;
    logic          clr_all, clr_set, set_val, wr_en;

    logic [LW-1:0] pc_line;
    logic [SB-1:0] pc_set;
    logic [TW-1:0] pc_tag;
    logic [WB-1:0] pc_word;
    logic [SB-1:0] ln_set;
    logic [TW-1:0] ln_tag;
    logic          hit;
    logic          unused_pc;

    assign unused_pc = ^PC[1:0];
    assign pc_line   = PC[63:WB+2];
    assign pc_set    = PC[WB+SB+1:WB+2];
    assign pc_tag    = PC[63:WB+SB+2];
    assign pc_word   = PC[WB+1:2];
    assign ln_set    = line_q[SB-1:0];
    assign ln_tag    = line_q[LW-1:SB];
    assign beat_inc  = beat_q + 1'b1;

    assign hit = (state_q == IDLE) && valid_q[pc_set]
               && (tag_q[pc_set] == pc_tag);

    assign icache_r     = hit;
    assign instruction  = hit ? data_q[pc_set][pc_word] : 32'h0;
    assign icache_fault = (state_q == ERR) && (pc_line == err_q);

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        err_d   = err_q;
        beat_d  = beat_q;
        fp_d    = fp_q;
        req_d   = MEM_REQ;
        addr_d  = MEM_ADDR;
        clr_all = FLUSH;
        clr_set = 1'b0;
        set_val = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!FLUSH && !hit) begin
                    line_d  = pc_line;
                    beat_d  = '0;
                    req_d   = 1'b1;
                    addr_d  = {pc_line, {(WB+2){1'b0}}};
                    clr_set = 1'b1;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (FLUSH) fp_d = 1'b1;
                if (MEM_REQ && MEM_ACK) begin
                    if (MEM_ERR) begin
                        req_d   = 1'b0;
                        err_d   = line_q;
                        fp_d    = 1'b0;
                        state_d = ERR;
                    end else begin
                        wr_en = 1'b1;
                        if (beat_q == WB'(LINE_WORDS - 1)) begin
                            // a flush seen at any point of the fill wins
                            set_val = !(fp_q || FLUSH);
                            fp_d    = 1'b0;
                            req_d   = 1'b0;
                            state_d = IDLE;
                        end else begin
                            beat_d = beat_inc;
                            addr_d = {line_q, beat_inc, 2'b00};
                        end
                    end
                end
            end
            ERR: begin
                if (FLUSH || (pc_line != err_q)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            beat_q   <= '0;
            line_q   <= '0;
            err_q    <= '0;
            fp_q     <= 1'b0;
            MEM_REQ  <= 1'b0;
            MEM_ADDR <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            line_q   <= line_d;
            err_q    <= err_d;
            fp_q     <= fp_d;
            MEM_REQ  <= req_d;
            MEM_ADDR <= addr_d;
            if (clr_all) begin
                valid_q <= '0;
            end else begin
                if (clr_set) valid_q[pc_set] <= 1'b0;
                if (set_val) valid_q[ln_set] <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) data_q[ln_set][beat_q] <= MEM_RDATA;
        if (set_val) tag_q[ln_set] <= ln_tag;
    end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache that answers the fetch stage's PC lookup with `icache_r` / `instruction`.
- On a miss it refills a whole line from the backing instruction memory through a req/ack handshake.
- It is the responder end of the fetch–icache interface. The fetch stage holds PC steady while `icache_r` is low and samples `instruction` at the posedge when `icache_r` is high.
- Also supports FENCE.I-style flush and reports memory bus errors.

Parameters:
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥ 2.
- SETS, 64, number of lines; power of two, ≥ 2.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- PC  in  64  fetch address; bits [1:0] ignored (misalignment is flagged by fetch).
- FLUSH  in  1  invalidate all lines (FENCE.I).
- icache_r  out  1  `instruction` is valid for the current PC.
- instruction  out  32  instruction word at PC.
- icache_fault  out  1  the line refill for the current PC returned a bus error.
- MEM_REQ  out  1  beat request to backing memory.
- MEM_ADDR  out  64  beat address, word aligned.
- MEM_ACK  in  1  beat accepted, with data valid this cycle.
- MEM_RDATA  in  32  beat data.
- MEM_ERR  in  1  bus error; qualified by MEM_ACK.

Behaviour:
- Address split, with WB = log2(LINE_WORDS) and SB = log2(SETS):
  - word = PC[WB+1:2]
  - set = PC[WB+SB+1:WB+2]
  - tag = PC[63:WB+SB+2]
- Storage per set: a valid bit, a tag, and LINE_WORDS data words. All are asynchronously read.
- hit = (state == IDLE) && valid[set] && (tag_arr[set] == tag). This is combinational, giving zero-cycle hit latency.
- icache_r = hit. instruction = data[set][word] when hit, else 32'h0.
- Reset, applied asynchronously:
  - state = IDLE; all valid bits = 0; beat counter = 0.
  - MEM_REQ = 0, MEM_ADDR = 0, icache_fault = 0, flush_pend = 0, err_line = 0.
  - Reset mid-refill aborts immediately and the partial line stays invalid.
- FSM states: IDLE, REFILL, ERR.
- IDLE:
  - If FLUSH: clear all valid bits this edge; no refill is started this cycle.
  - Else if !hit: latch base = {PC[63:WB+2], WB+2 zero bits}; beat = 0; MEM_REQ = 1; MEM_ADDR = base; go to REFILL.
- REFILL:
  - MEM_REQ stays high and MEM_ADDR = base + 4·beat until MEM_ACK.
  - On MEM_ACK with !MEM_ERR: write data[base set][beat] = MEM_RDATA; beat++.
  - On the ACK of the last beat (beat == LINE_WORDS−1):
    - Set valid and tag for the line unless flush_pend.
    - Clear flush_pend; MEM_REQ = 0; go to IDLE.
    - The hit is visible the cycle after the last ACK.
  - On MEM_ACK with MEM_ERR: MEM_REQ = 0; line stays invalid; latch err_line = base; go to ERR.
  - PC changes during REFILL do not abort the refill. The latched line completes and IDLE re-evaluates the new PC.
  - FLUSH during REFILL sets flush_pend; the flush wins over the in-flight line.
- ERR:
  - icache_fault = 1 while PC[63:WB+2] == err_line[63:WB+2].
  - When PC moves to a different line, or on FLUSH: icache_fault = 0 and go to IDLE.
  - FLUSH in ERR also clears all valid bits.
  - icache_r = 0 throughout ERR.
- Memory handshake:
  - At most one beat is outstanding.
  - The next beat's address is presented in the cycle after the ACK, so MEM_REQ stays continuously high between beats.
  - MEM_ACK while MEM_REQ = 0 is ignored.
- Fills are sequential from word 0 (no critical-word-first). The fetch stalls until the whole line is valid.
- A refill overwrites any previously valid line in that set; the old line is invalid from the start of the refill.

Test Plan:
- Cold miss: reset, PC = 0, memory ACKs each beat 1 cycle after REQ with data 0x10,0x14,0x18,0x1C → MEM_ADDR sequence 0,4,8,12; icache_r = 0 until the cycle after the 4th ACK, then icache_r = 1, instruction = 0x10. PC = 8 then gives instruction = 0x18 in the same cycle with no MEM_REQ.
- Conflict eviction: line 0 loaded, PC = 0x400 (same set 0, different tag) → refill at 0x400..0x40C. Returning to PC = 0 misses and re-refills from address 0.
- Flush: lines at 0x0 and 0x10 valid, pulse FLUSH in IDLE → next cycle both miss. FLUSH during the 2nd beat of a refill → refill completes (4 ACKs), line stays invalid, immediate re-request of the same base.
- Bus error: MEM_ERR with the ACK on beat 2 of PC = 0x20 → MEM_REQ drops, icache_fault = 1, icache_r = 0. Changing PC to 0x40 → icache_fault = 0 and a new refill at 0x40.
- Backpressure and PC change: ACK delayed 5 cycles per beat, PC changes 0x0→0x100 mid-refill → MEM_ADDR holds steady until each ACK, the 0x0 line completes, then a refill of 0x100 starts.
- Async reset mid-refill: assert RESET between beats 1 and 2 → MEM_REQ = 0 immediately without a clock edge; after release, PC = 0 misses again and the refill restarts at beat 0.
